// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller: FSM state
// encoding, opcode constants and the "instruction reads rt" decode.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_IMEM_WAIT = 2'd2
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // True when the ID instruction reads its rt field as a source operand.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard
// controller (slave): hazard inputs in, stage enables/flushes out.
interface pipeline_hazard_ctrl_if;
  logic [5:0]  opcode_ID;
  logic [4:0]  ID_RS;
  logic [4:0]  ID_RT;
  logic [4:0]  EX_RT;
  logic        EX_MemRead;
  logic        EX_BrTaken;
  logic        MEM_Access;
  logic        dmem_ready;
  logic        imem_ready;
  logic        PC_write;
  logic        IF_ID_write;
  logic        ID_EX_write;
  logic        EX_MEM_write;
  logic        MEM_WB_write;
  logic        IF_ID_flush;
  logic        ID_EX_flush;
  logic        dmem_req;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt;

  modport master (
    output opcode_ID, ID_RS, ID_RT, EX_RT, EX_MemRead, EX_BrTaken,
           MEM_Access, dmem_ready, imem_ready,
    input  PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
           IF_ID_flush, ID_EX_flush, dmem_req, state_o, stall_cnt
  );

  modport slave (
    input  opcode_ID, ID_RS, ID_RT, EX_RT, EX_MemRead, EX_BrTaken,
           MEM_Access, dmem_ready, imem_ready,
    output PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
           IF_ID_flush, ID_EX_flush, dmem_req, state_o, stall_cnt
  );
endinterface

// File: rtl/load_use_detect.sv
// Load-use comparator: the load in EX writes a register the ID
// instruction reads. Register 0 never creates a dependency.
module load_use_detect
  import mips_pipe_pkg::*;
(
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic [5:0] i_opcode_id,
  output logic       o_lu
);

  assign o_lu = i_ex_mem_read && (i_ex_rt != 5'd0) &&
                ((i_ex_rt == i_id_rs) ||
                 ((i_ex_rt == i_id_rt) && uses_rt(i_opcode_id)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: freezes the whole pipe on a data-memory
// miss, flushes on taken branches, bubbles fetch misses and load-use
// hazards. Only the FSM state and the stall counter are registered.
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  state_e      r_state;
  logic [15:0] r_stall_cnt;

  logic w_lu;
  logic w_in_run;
  logic w_in_dwait;
  logic w_in_iwait;
  logic w_freeze;
  logic w_imem_stall;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_id_ex_write;
  logic w_ex_mem_write;
  logic w_mem_wb_write;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_dmem_req;

  load_use_detect u_load_use_detect (
    .i_ex_mem_read (hz.EX_MemRead),
    .i_ex_rt       (hz.EX_RT),
    .i_id_rs       (hz.ID_RS),
    .i_id_rt       (hz.ID_RT),
    .i_opcode_id   (hz.opcode_ID),
    .o_lu          (w_lu)
  );

  assign w_in_run   = (r_state == ST_RUN);
  assign w_in_dwait = (r_state == ST_DMEM_WAIT);
  assign w_in_iwait = (r_state == ST_IMEM_WAIT);

  // The MEM stage cannot complete, so nothing anywhere may move.
  assign w_freeze = (w_in_dwait && !hz.dmem_ready) ||
                    (w_in_run && hz.MEM_Access && !hz.dmem_ready);

  // A fetch stall is only judged in RUN/IMEM_WAIT; the cycle leaving
  // DMEM_WAIT advances normally and fetch is re-evaluated afterwards.
  assign w_imem_stall = (w_in_run || w_in_iwait) && !hz.imem_ready;

  // Stage enables and flushes, resolved by priority freeze > branch > fetch > load-use.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_id_ex_write  = 1'b1;
    w_ex_mem_write = 1'b1;
    w_mem_wb_write = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_dmem_req     = (w_in_run && hz.MEM_Access) || w_in_dwait;

    if (rst) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_id_ex_write  = 1'b0;
      w_ex_mem_write = 1'b0;
      w_mem_wb_write = 1'b0;
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
      w_dmem_req     = 1'b0;
    end else if (w_freeze) begin
      // EX is held, so a coincident branch is simply seen again later.
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_id_ex_write  = 1'b0;
      w_ex_mem_write = 1'b0;
      w_mem_wb_write = 1'b0;
    end else if (hz.EX_BrTaken) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      // With the fetch still outstanding, the PC must not move yet.
      if (w_in_iwait && !hz.imem_ready) w_pc_write = 1'b0;
    end else if (w_imem_stall) begin
      w_pc_write    = 1'b0;
      w_if_id_flush = 1'b1;
    end else if (w_lu) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
    end
  end

  // FSM and stall counter; reset abandons any pending wait at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        ST_RUN: begin
          if (hz.MEM_Access && !hz.dmem_ready) r_state <= ST_DMEM_WAIT;
          else if (!hz.imem_ready)             r_state <= ST_IMEM_WAIT;
          else                                 r_state <= ST_RUN;
        end
        ST_DMEM_WAIT: begin
          r_state <= hz.dmem_ready ? ST_RUN : ST_DMEM_WAIT;
        end
        ST_IMEM_WAIT: begin
          if (hz.MEM_Access && !hz.dmem_ready) r_state <= ST_DMEM_WAIT;
          else if (hz.imem_ready)              r_state <= ST_RUN;
          else                                 r_state <= ST_IMEM_WAIT;
        end
        default: r_state <= ST_RUN;
      endcase
      if (!w_pc_write) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign hz.PC_write     = w_pc_write;
  assign hz.IF_ID_write  = w_if_id_write;
  assign hz.ID_EX_write  = w_id_ex_write;
  assign hz.EX_MEM_write = w_ex_mem_write;
  assign hz.MEM_WB_write = w_mem_wb_write;
  assign hz.IF_ID_flush  = w_if_id_flush;
  assign hz.ID_EX_flush  = w_id_ex_flush;
  assign hz.dmem_req     = w_dmem_req;
  assign hz.state_o      = r_state;
  assign hz.stall_cnt    = r_stall_cnt;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising edge) and rst input 1 (asynchronous, active-high).
REQ-002 opcode_ID  input 6: opcode of the instruction in the ID stage.
REQ-003 ID_RS, ID_RT  input 5 each: source register fields in ID.
REQ-004 EX_RT  input 5: rt field of the instruction in EX.
REQ-005 EX_MemRead  input 1: the EX instruction is a load (LW).
REQ-006 EX_BrTaken  input 1: a branch or jump resolved taken in EX this cycle.
REQ-007 MEM_Access  input 1: the MEM-stage instruction is LW or SW.
REQ-008 dmem_ready  input 1: data memory completes the access this cycle.
REQ-009 imem_ready  input 1: instruction memory returns the fetch word this cycle.
REQ-010 Write-enable outputs, 1 bit each: PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write.
REQ-011 Flush outputs, 1 bit each: IF_ID_flush, ID_EX_flush (flush = load NOP into the register).
REQ-012 dmem_req  output 1: data-memory request strobe.
REQ-013 state_o  output 2: current FSM state (debug).
REQ-014 stall_cnt  output 16: count of cycles in which PC_write=0.

Function
REQ-015 FSM states SHALL be RUN=0, DMEM_WAIT=1, IMEM_WAIT=2 (3 is unused and SHALL recover to RUN on the next edge).
REQ-016 Define freeze = (state==DMEM_WAIT && !dmem_ready) || (state==RUN && MEM_Access && !dmem_ready).
- When freeze=1, all five write enables SHALL be 0 and both flushes SHALL be 0.
REQ-017 dmem_req SHALL be 1 whenever MEM_Access=1 in RUN, and continuously while in DMEM_WAIT.
REQ-018 Transition RUN->DMEM_WAIT SHALL occur when MEM_Access=1 and dmem_ready=0.
- Transition DMEM_WAIT->RUN SHALL occur on the first cycle with dmem_ready=1; that cycle advances the pipeline (freeze=0).
REQ-019 Load-use hazard is defined as lu = EX_MemRead && EX_RT!=0 && (EX_RT==ID_RS || (EX_RT==ID_RT && uses_rt)).
- uses_rt is true for opcode_ID equal to 000000 (R-type), 101011 (SW), 000100 (BEQ) or 000101 (BNE).
REQ-020 When freeze=0 and lu=1 and EX_BrTaken=0, the outputs SHALL be PC_write=0, IF_ID_write=0, ID_EX_flush=1, with all other enables 1.
- This bubble is purely combinational and lasts 1 cycle; there is no state change.
REQ-021 When freeze=0 and EX_BrTaken=1, the outputs SHALL be IF_ID_flush=1, ID_EX_flush=1, with all enables 1.
- The branch overrides lu.
REQ-022 A branch coincident with freeze SHALL be deferred: EX is held, so the flush is issued on the first non-frozen cycle.
REQ-023 When freeze=0 and imem_ready=0 in RUN or IMEM_WAIT, the outputs SHALL be PC_write=0 and IF_ID_flush=1, with the downstream enables 1.
- The state SHALL be IMEM_WAIT until imem_ready=1, then RUN.
REQ-024 Priority SHALL be freeze > EX_BrTaken > imem stall > lu.
- A branch during IMEM_WAIT SHALL flush ID_EX and keep PC_write=0.
REQ-025 A data miss arriving while in IMEM_WAIT SHALL move the FSM to DMEM_WAIT.
- The fetch stall SHALL be re-evaluated on return to RUN.
REQ-026 With no hazard, no miss and no branch, all enables SHALL be 1, all flushes 0 and dmem_req=MEM_Access.
REQ-027 stall_cnt SHALL increment by 1 on every edge where PC_write=0 and rst=0, wrapping from 0xFFFF to 0x0000.

Reset
REQ-028 While rst=1: state=RUN, stall_cnt=0, all write enables 0, both flushes 1, dmem_req=0, state_o=0.
REQ-029 A reset asserted mid-DMEM_WAIT or mid-IMEM_WAIT SHALL abandon the wait immediately (dmem_req drops asynchronously).
REQ-030 After rst deasserts, the first edge SHALL evaluate from RUN.

Structure
REQ-031 Shared package mips_pipe_pkg SHALL hold:
- the FSM state encoding;
- opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_BNE=000101.
REQ-032 The load-use comparator (REQ-019) SHALL be a separate combinational sub-module, load_use_detect.
REQ-033 Only state and stall_cnt SHALL be registered; all other outputs are combinational from state and inputs.

Verification
REQ-034 Load-use: EX_MemRead=1, EX_RT=5, ID_RS=5, opcode_ID=000000 -> one cycle with PC_write=0, IF_ID_write=0, ID_EX_flush=1; stall_cnt 0->1.
REQ-035 rt=0 guard: same as REQ-034 with EX_RT=0 -> no stall; all enables 1.
REQ-036 Data miss: MEM_Access=1, dmem_ready low for 3 cycles then high -> state_o 0,1,1,1,0; all enables 0 for 3 cycles; dmem_req high for 4 cycles; stall_cnt=3.
REQ-037 Branch during miss: EX_BrTaken=1 held with dmem_ready low for 2 cycles -> no flush while frozen; IF_ID_flush=ID_EX_flush=1 on the dmem_ready cycle.
REQ-038 Fetch miss plus load-use: imem_ready=0 for 2 cycles with lu=1 -> PC_write=0, IF_ID_flush=1, state_o=2; ID_EX_flush=0 (the imem stall outranks lu).
REQ-039 Reset mid-wait: rst pulses during DMEM_WAIT -> immediate state_o=0, stall_cnt=0, dmem_req=0; counter wrap tested from preload 0xFFFF -> 0x0000.
